// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: widths, operation
// encodings, FSM state encoding, exception bit positions, RAM strobe levels
// and small operation-decoding helpers.
package mem_lsu_pkg;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned OPW  = 4;
  localparam int unsigned RW   = 5;
  localparam int unsigned SELW = 4;
  localparam int unsigned EXCW = 2;

  // Operation encodings on req_op; 10..15 are no-ops.
  localparam logic [OPW-1:0] OP_LB  = 4'd0;
  localparam logic [OPW-1:0] OP_LBU = 4'd1;
  localparam logic [OPW-1:0] OP_LH  = 4'd2;
  localparam logic [OPW-1:0] OP_LHU = 4'd3;
  localparam logic [OPW-1:0] OP_LW  = 4'd4;
  localparam logic [OPW-1:0] OP_SB  = 4'd5;
  localparam logic [OPW-1:0] OP_SH  = 4'd6;
  localparam logic [OPW-1:0] OP_SW  = 4'd7;
  localparam logic [OPW-1:0] OP_LL  = 4'd8;
  localparam logic [OPW-1:0] OP_SC  = 4'd9;

  // Exception bit positions within rsp_excp.
  localparam int unsigned EXC_ADEL = 0;
  localparam int unsigned EXC_ADES = 1;

  // RAM strobe levels.
  localparam logic CE_ENABLE  = 1'b1;
  localparam logic CE_DISABLE = 1'b0;
  localparam logic WE_WRITE   = 1'b1;
  localparam logic WE_READ    = 1'b0;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } lsu_size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  // Request fields kept past the accept edge.
  typedef struct packed {
    logic [OPW-1:0] op;
    logic [1:0]     off;
    logic [RW-1:0]  wd;
  } lsu_req_t;

  function automatic lsu_size_e op_size(input logic [OPW-1:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB:       return SZ_BYTE;
      OP_LH, OP_LHU, OP_SH:       return SZ_HALF;
      OP_LW, OP_SW, OP_LL, OP_SC: return SZ_WORD;
      default:                    return SZ_NONE;
    endcase
  endfunction

  function automatic logic op_is_load(input logic [OPW-1:0] op);
    case (op)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LL: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [OPW-1:0] op);
    case (op)
      OP_SB, OP_SH, OP_SW: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

  function automatic logic op_misaligned(input logic [OPW-1:0] op, input logic [1:0] off);
    case (op_size(op))
      SZ_HALF: return off[0];
      SZ_WORD: return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Pipeline-side request/response and data-RAM port bundle of the LSU.
//   slave  : LSU view (drives req_ready, ram_*, rsp_*)
//   master : pipeline + RAM view (drives req_*, flush, ram_rdata)
interface mem_lsu_if;
  import mem_lsu_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic [OPW-1:0]       req_op;
  logic [AW-1:0]        req_addr;
  logic [DW-1:0]        req_wdata;
  logic [RW-1:0]        req_wd;
  logic                 flush;

  logic                 ram_ce;
  logic                 ram_we;
  logic [AW-1:0]        ram_addr;
  logic [SELW-1:0]      ram_sel;
  logic [DW-1:0]        ram_wdata;
  logic [DW-1:0]        ram_rdata;

  logic                 rsp_valid;
  logic                 rsp_wreg;
  logic [RW-1:0]        rsp_wd;
  logic [DW-1:0]        rsp_wdata;
  logic [EXCW-1:0]      rsp_excp;
  logic [AW-1:0]        rsp_badaddr;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_wd, flush, ram_rdata,
    output req_ready, ram_ce, ram_we, ram_addr, ram_sel, ram_wdata,
    output rsp_valid, rsp_wreg, rsp_wd, rsp_wdata, rsp_excp, rsp_badaddr
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_wd, flush, ram_rdata,
    input  req_ready, ram_ce, ram_we, ram_addr, ram_sel, ram_wdata,
    input  rsp_valid, rsp_wreg, rsp_wd, rsp_wdata, rsp_excp, rsp_badaddr
  );
endinterface

// File: rtl/mem_lsu_lane_align.sv
// Big-endian byte-lane helper (combinational).
//   op_i/off_i : operation and byte offset within the word
//   wdata_i    : store data (low bits for byte/halfword)
//   rdata_i    : RAM read word
//   sel_c      : byte enables, bit 3 = bits 31:24
//   wdata_c    : lane-replicated store data
//   ldata_c    : extracted and sign/zero-extended load data
module lsu_lane_align
  import mem_lsu_pkg::*;
(
  input  logic [OPW-1:0]  op_i,
  input  logic [1:0]      off_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [DW-1:0]   rdata_i,
  output logic [SELW-1:0] sel_c,
  output logic [DW-1:0]   wdata_c,
  output logic [DW-1:0]   ldata_c
);

  logic [4:0]  byte_sh;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic        sext;

  always_comb begin
    sel_c   = '0;
    wdata_c = '0;
    ldata_c = '0;
    // Offset 0 is the most significant lane, so shift by (3-off)*8.
    byte_sh = {~off_i, 3'b000};
    rbyte   = 8'(rdata_i >> byte_sh);
    rhalf   = off_i[1] ? rdata_i[15:0] : rdata_i[31:16];
    sext    = (op_i == OP_LB) || (op_i == OP_LH);
    case (op_size(op_i))
      SZ_BYTE: begin
        sel_c   = 4'b1000 >> off_i;
        wdata_c = {4{wdata_i[7:0]}};
        ldata_c = sext ? {{24{rbyte[7]}}, rbyte} : {24'h0, rbyte};
      end
      SZ_HALF: begin
        sel_c   = off_i[1] ? 4'b0011 : 4'b1100;
        wdata_c = {2{wdata_i[15:0]}};
        ldata_c = sext ? {{16{rhalf[15]}}, rhalf} : {16'h0, rhalf};
      end
      SZ_WORD: begin
        sel_c   = 4'b1111;
        wdata_c = wdata_i;
        ldata_c = rdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: accepts one op, drives the word-organised data
// RAM for one ACCESS cycle, returns a one-cycle registered writeback response,
// flags misaligned accesses and keeps the LL/SC link bit.
//   clk, rst : clock, synchronous active-low reset
//   bus      : request / RAM / response bundle (slave view)
//   llbit_o  : current link bit
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  mem_lsu_if.slave  bus,
  output logic      llbit_o
);

  lsu_state_e      state_q, state_d;
  lsu_req_t        req_q, req_d;
  logic            sc_ok_q, sc_ok_d;
  logic            llbit_q, llbit_d;
  logic            req_ready_q, req_ready_d;

  logic            ram_ce_q, ram_ce_d;
  logic            ram_we_q, ram_we_d;
  logic [AW-1:0]   ram_addr_q, ram_addr_d;
  logic [SELW-1:0] ram_sel_q, ram_sel_d;
  logic [DW-1:0]   ram_wdata_q, ram_wdata_d;

  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_wreg_q, rsp_wreg_d;
  logic [RW-1:0]   rsp_wd_q, rsp_wd_d;
  logic [DW-1:0]   rsp_wdata_q, rsp_wdata_d;
  logic [EXCW-1:0] rsp_excp_q, rsp_excp_d;
  logic [AW-1:0]   rsp_badaddr_q, rsp_badaddr_d;

  logic            in_idle_c;
  logic            nop_c;
  logic            fault_c;
  logic [OPW-1:0]  al_op_c;
  logic [1:0]      al_off_c;
  logic [SELW-1:0] al_sel_c;
  logic [DW-1:0]   al_wdata_c;
  logic [DW-1:0]   al_ldata_c;

  assign in_idle_c = (state_q == ST_IDLE);
  assign nop_c     = (op_size(bus.req_op) == SZ_NONE);
  assign fault_c   = op_misaligned(bus.req_op, bus.req_addr[1:0]);

  // One lane aligner shared in time: request fields in IDLE (sel/wdata),
  // latched op/offset in ACCESS (load extraction).
  assign al_op_c  = in_idle_c ? bus.req_op : req_q.op;
  assign al_off_c = in_idle_c ? bus.req_addr[1:0] : req_q.off;

  lsu_lane_align u_align (
    .op_i    (al_op_c),
    .off_i   (al_off_c),
    .wdata_i (bus.req_wdata),
    .rdata_i (bus.ram_rdata),
    .sel_c   (al_sel_c),
    .wdata_c (al_wdata_c),
    .ldata_c (al_ldata_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; faults and no-ops skip ACCESS.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) state_d = (nop_c || fault_c) ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values; every output register returns to 0
  // unless set for the coming cycle.
  always_comb begin
    req_d         = req_q;
    sc_ok_d       = sc_ok_q;
    llbit_d       = llbit_q & ~bus.flush;
    req_ready_d   = 1'b0;
    ram_ce_d      = CE_DISABLE;
    ram_we_d      = WE_READ;
    ram_addr_d    = '0;
    ram_sel_d     = '0;
    ram_wdata_d   = '0;
    rsp_valid_d   = 1'b0;
    rsp_wreg_d    = 1'b0;
    rsp_wd_d      = '0;
    rsp_wdata_d   = '0;
    rsp_excp_d    = '0;
    rsp_badaddr_d = '0;

    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (bus.req_valid) begin
          req_ready_d = 1'b0;
          req_d.op    = bus.req_op;
          req_d.off   = bus.req_addr[1:0];
          req_d.wd    = bus.req_wd;
          sc_ok_d     = 1'b0;
          if (bus.req_op == OP_SC) llbit_d = 1'b0;
          if (nop_c) begin
            rsp_valid_d = 1'b1;
            rsp_wd_d    = bus.req_wd;
          end else if (fault_c) begin
            rsp_valid_d   = 1'b1;
            rsp_wd_d      = bus.req_wd;
            rsp_badaddr_d = bus.req_addr;
            if (op_is_store(bus.req_op) || (bus.req_op == OP_SC)) rsp_excp_d[EXC_ADES] = 1'b1;
            else                                                  rsp_excp_d[EXC_ADEL] = 1'b1;
          end else begin
            ram_ce_d   = CE_ENABLE;
            ram_addr_d = {bus.req_addr[AW-1:2], 2'b00};
            ram_sel_d  = al_sel_c;
            if (op_is_store(bus.req_op)) begin
              ram_we_d    = WE_WRITE;
              ram_wdata_d = al_wdata_c;
            end else if (bus.req_op == OP_SC) begin
              // A flush arriving with the SC already kills the link.
              sc_ok_d = llbit_q & ~bus.flush;
              if (sc_ok_d) begin
                ram_we_d    = WE_WRITE;
                ram_wdata_d = al_wdata_c;
              end else begin
                ram_sel_d = '0;
              end
            end
          end
        end
      end
      ST_ACCESS: begin
        rsp_valid_d = 1'b1;
        rsp_wd_d    = req_q.wd;
        if (op_is_load(req_q.op)) begin
          rsp_wreg_d  = 1'b1;
          rsp_wdata_d = al_ldata_c;
        end else if (req_q.op == OP_SC) begin
          rsp_wreg_d  = 1'b1;
          rsp_wdata_d = DW'(sc_ok_q);
        end
        // Flush wins over an LL completing in the same cycle.
        if (req_q.op == OP_LL) llbit_d = ~bus.flush;
      end
      ST_RESP: req_ready_d = 1'b1;
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      req_q         <= '0;
      sc_ok_q       <= 1'b0;
      llbit_q       <= 1'b0;
      req_ready_q   <= 1'b1;
      ram_ce_q      <= CE_DISABLE;
      ram_we_q      <= WE_READ;
      ram_addr_q    <= '0;
      ram_sel_q     <= '0;
      ram_wdata_q   <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_wreg_q    <= 1'b0;
      rsp_wd_q      <= '0;
      rsp_wdata_q   <= '0;
      rsp_excp_q    <= '0;
      rsp_badaddr_q <= '0;
    end else begin
      req_q         <= req_d;
      sc_ok_q       <= sc_ok_d;
      llbit_q       <= llbit_d;
      req_ready_q   <= req_ready_d;
      ram_ce_q      <= ram_ce_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_sel_q     <= ram_sel_d;
      ram_wdata_q   <= ram_wdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_wreg_q    <= rsp_wreg_d;
      rsp_wd_q      <= rsp_wd_d;
      rsp_wdata_q   <= rsp_wdata_d;
      rsp_excp_q    <= rsp_excp_d;
      rsp_badaddr_q <= rsp_badaddr_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.ram_ce      = ram_ce_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_sel     = ram_sel_q;
  assign bus.ram_wdata   = ram_wdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_wreg    = rsp_wreg_q;
  assign bus.rsp_wd      = rsp_wd_q;
  assign bus.rsp_wdata   = rsp_wdata_q;
  assign bus.rsp_excp    = rsp_excp_q;
  assign bus.rsp_badaddr = rsp_badaddr_q;
  assign llbit_o         = llbit_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed scenarios followed by random
// operations, compared against a byte-addressed reference memory and link
// flag kept in the bench.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic llbit;
  int   errors = 0;
  int   checks = 0;
  int   ce_count = 0;

  always #5 clk = ~clk;

  mem_lsu_if bus ();

  mem_lsu u_dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .llbit_o (llbit)
  );

  // Word RAM seen by the DUT: 256 words, big-endian lanes.
  logic [31:0] ram [0:255];
  assign bus.ram_rdata = ram[bus.ram_addr[9:2]];

  always @(posedge clk) begin
    if (bus.ram_ce && bus.ram_we) begin
      for (int k = 0; k < 4; k++)
        if (bus.ram_sel[k]) ram[bus.ram_addr[9:2]][8*k +: 8] <= bus.ram_wdata[8*k +: 8];
    end
    if (bus.ram_ce) ce_count <= ce_count + 1;
  end

  // Reference model state.
  logic [7:0] ref_mem [0:1023];
  bit         ref_ll;

  function automatic int op_sz(input logic [3:0] op);
    case (op)
      4'd0, 4'd1, 4'd5:       return 1;
      4'd2, 4'd3, 4'd6:       return 2;
      4'd4, 4'd7, 4'd8, 4'd9: return 4;
      default:                return 0;
    endcase
  endfunction

  function automatic bit op_ld(input logic [3:0] op);
    return (op <= 4'd4) || (op == 4'd8);
  endfunction

  function automatic bit op_st(input logic [3:0] op);
    return (op >= 4'd5) && (op <= 4'd7);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic init_word(input int byte_addr, input logic [31:0] v);
    ram[byte_addr / 4] <= v;
    for (int k = 0; k < 4; k++) ref_mem[(byte_addr & ~3) + k] = v[31-8*k -: 8];
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
    check({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, ".rsp_wdata"}, bus.rsp_wdata, 32'd0);
    check({tag, ".ram_ce"}, 32'(bus.ram_ce), 32'd0);
  endtask

  task automatic check_rsp(input logic [4:0] rd, input bit wreg, input logic [31:0] data,
                           input logic [1:0] excp, input logic [31:0] bad);
    check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("rsp_wreg", 32'(bus.rsp_wreg), 32'(wreg));
    check("rsp_wd", 32'(bus.rsp_wd), 32'(rd));
    check("rsp_wdata", bus.rsp_wdata, data);
    check("rsp_excp", 32'(bus.rsp_excp), 32'(excp));
    check("rsp_badaddr", bus.rsp_badaddr, bad);
    check("req_ready_busy", 32'(bus.req_ready), 32'd0);
  endtask

  // Issue one op and check the RAM port and response against the model.
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] rd, input bit fl);
    int          s, lane, ce0;
    bit          nop, fault, sc_ok, acc, wr, fl_eff;
    logic [3:0]  e_sel;
    logic [31:0] e_wdata, e_data, v;
    logic [1:0]  e_excp;

    s      = op_sz(op);
    nop    = (s == 0);
    fault  = !nop && ((int'(addr) % s) != 0);
    acc    = !nop && !fault;
    sc_ok  = (op == 4'd9) && ref_ll;
    wr     = acc && (op_st(op) || sc_ok);
    fl_eff = fl && acc;

    e_sel = '0;
    if (acc && !((op == 4'd9) && !sc_ok))
      for (int k = 0; k < s; k++) begin
        lane = int'(addr[1:0]) + k;
        e_sel[3 - lane] = 1'b1;
      end
    e_wdata = '0;
    if (wr)
      for (int j = 0; j < 4; j++) e_wdata[31-8*j -: 8] = 8'(wd >> (8 * (s - 1 - (j % s))));

    e_data = '0;
    if (acc && op_ld(op)) begin
      v = '0;
      for (int k = 0; k < s; k++) v = (v << 8) | 32'(ref_mem[int'(addr) + k]);
      if (op == 4'd0) v = {{24{v[7]}}, v[7:0]};
      if (op == 4'd2) v = {{16{v[15]}}, v[15:0]};
      e_data = v;
    end else if (acc && op == 4'd9) begin
      e_data = 32'(sc_ok);
    end
    e_excp = '0;
    if (fault) e_excp = (op_st(op) || op == 4'd9) ? 2'b10 : 2'b01;

    @(negedge clk);
    check_idle("pre");
    ce0           = ce_count;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_wd    = rd;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_wdata = $urandom;
    if (acc) begin
      check("acc.ram_ce", 32'(bus.ram_ce), 32'd1);
      check("acc.ram_we", 32'(bus.ram_we), 32'(wr));
      check("acc.ram_addr", bus.ram_addr, addr & ~32'd3);
      check("acc.ram_sel", 32'(bus.ram_sel), 32'(e_sel));
      check("acc.ram_wdata", bus.ram_wdata, e_wdata);
      check("acc.rsp_valid", 32'(bus.rsp_valid), 32'd0);
      if (fl_eff) bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
    end
    check_rsp(rd, acc && (op_ld(op) || op == 4'd9), e_data, e_excp, fault ? addr : 32'd0);
    check("ram_ce_count", 32'(ce_count - ce0), acc ? 32'd1 : 32'd0);

    if (wr)
      for (int k = 0; k < s; k++) ref_mem[int'(addr) + k] = 8'(wd >> (8 * (s - 1 - k)));
    if (acc && op == 4'd8) ref_ll = 1'b1;
    if (op == 4'd9) ref_ll = 1'b0;
    if (fl_eff) ref_ll = 1'b0;
    check("llbit", 32'(llbit), 32'(ref_ll));
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    ref_ll = 1'b0;
    check("flush.llbit", 32'(llbit), 32'd0);
  endtask

  initial begin
    logic [31:0] v, a;
    logic [3:0]  op;
    int          s;

    rst           = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wd    = '0;
    bus.flush     = 1'b0;
    ref_ll        = 1'b0;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      init_word(i * 4, v);
    end

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    check("reset.llbit", 32'(llbit), 32'd0);
    check("reset.rsp_excp", 32'(bus.rsp_excp), 32'd0);
    rst = 1'b1;

    // Word store, byte store, signed/unsigned byte loads.
    run_op(4'd7, 32'h100, 32'h12345678, 5'd3, 1'b0);
    run_op(4'd5, 32'h101, 32'h000000AB, 5'd4, 1'b0);
    run_op(4'd0, 32'h101, 32'h0, 5'd5, 1'b0);
    check("lb_value", bus.rsp_wdata, 32'hFFFFFFAB);
    run_op(4'd1, 32'h101, 32'h0, 5'd6, 1'b0);
    check("lbu_value", bus.rsp_wdata, 32'h000000AB);

    // Halfword load from the low lanes, then a misaligned word load.
    @(negedge clk);
    init_word(32'h100, 32'h12348001);
    run_op(4'd2, 32'h102, 32'h0, 5'd7, 1'b0);
    check("lh_value", bus.rsp_wdata, 32'hFFFF8001);
    run_op(4'd4, 32'h102, 32'h0, 5'd8, 1'b0);
    check("lw_adel_bad", bus.rsp_badaddr, 32'h102);

    // LL/SC pair, repeated SC, flush-killed link, flush on LL completion.
    run_op(4'd8, 32'h200, 32'h0, 5'd9, 1'b0);
    run_op(4'd9, 32'h200, 32'd5, 5'd10, 1'b0);
    check("sc_ok_flag", bus.rsp_wdata, 32'd1);
    run_op(4'd9, 32'h200, 32'd6, 5'd11, 1'b0);
    check("sc_fail_flag", bus.rsp_wdata, 32'd0);
    run_op(4'd4, 32'h200, 32'h0, 5'd12, 1'b0);
    check("sc_word", bus.rsp_wdata, 32'd5);
    run_op(4'd8, 32'h200, 32'h0, 5'd9, 1'b0);
    pulse_flush();
    run_op(4'd9, 32'h200, 32'd7, 5'd10, 1'b0);
    run_op(4'd8, 32'h200, 32'h0, 5'd9, 1'b1);
    check("ll_flush_llbit", 32'(llbit), 32'd0);
    run_op(4'd12, 32'h0, 32'h0, 5'd1, 1'b0);

    // Reset during the ACCESS cycle of a load: no response ever appears.
    run_op(4'd8, 32'h204, 32'h0, 5'd2, 1'b0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 4'd4;
    bus.req_addr  = 32'h204;
    bus.req_wd    = 5'd3;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rstmid.ram_ce", 32'(bus.ram_ce), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst    = 1'b1;
    ref_ll = 1'b0;
    check_idle("rstmid");
    check("rstmid.llbit", 32'(llbit), 32'd0);
    @(negedge clk);
    check("rstmid.rsp_valid2", 32'(bus.rsp_valid), 32'd0);

    // Random operations.
    for (int n = 0; n < 300; n++) begin
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) op = ($urandom_range(0, 1) == 0) ? 4'd8 : 4'd9;
      a = 32'($urandom_range(0, 1023));
      s = op_sz(op);
      if ((s > 1) && ($urandom_range(0, 3) != 0)) a = a & ~32'(s - 1);
      if ((op == 4'd8 || op == 4'd9) && ($urandom_range(0, 1) == 0)) a = 32'h300;
      run_op(op, a, $urandom, 5'($urandom_range(0, 31)), ($urandom_range(0, 7) == 0));
    end

    @(negedge clk);
    check_idle("end");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit for the MEM stage: accepts one memory operation from the EX/MEM pipeline register and drives the word-organised data RAM port (chip enable, write enable, address, byte select, write data). It extracts and sign/zero-extends load data, detects misaligned addresses, and maintains the LL/SC link bit. It sits directly upstream of the data RAM and returns a registered writeback response toward MEM/WB.

## Interface
- `AW`, 32, address width; RAM index is `ram_addr[AW-1:2]`.
- `DW`, 32, data width; fixed at 32, big-endian byte lanes.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request; high only in IDLE.
- `req_op`  in  4  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 SB, 6 SH, 7 SW, 8 LL, 9 SC; 10–15 no-op.
- `req_addr`  in  AW  byte address.
- `req_wdata`  in  DW  store data, in the low bits for SB/SH.
- `req_wd`  in  5  destination register.
- `flush`  in  1  exception/ERET; clears the link bit.
- `ram_ce`, `ram_we`  out  1  RAM chip/write enable.
- `ram_addr`  out  AW  word-aligned address (`[1:0]`=0).
- `ram_sel`  out  4  byte enables; bit 3 = bits 31:24.
- `ram_wdata`  out  DW  lane-replicated store data.
- `ram_rdata`  in  DW  combinational RAM read data.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_wreg`  out  1  register write required.
- `rsp_wd`  out  5  destination register.
- `rsp_wdata`  out  DW  load result / SC flag.
- `rsp_excp`  out  2  bit0 AdEL, bit1 AdES.
- `rsp_badaddr`  out  AW  faulting address when `rsp_excp`≠0, else 0.
- `llbit_o`  out  1  current link bit.

## Operation
- FSM states: IDLE, ACCESS, RESP. Handshake: `req_valid && req_ready` in IDLE latches the op, address, write data and `req_wd`.
- Alignment check at accept:
  - Halfword ops need `addr[0]`=0.
  - Word ops and LL/SC need `addr[1:0]`=0.
  - Misaligned: go IDLE→RESP, no RAM access. Loads and LL set AdEL; stores and SC set AdES. `rsp_wreg`=0.
- Otherwise IDLE→ACCESS→RESP→IDLE. A no-op also goes IDLE→RESP, with `rsp_wreg`=0.
- ACCESS drives `ram_ce`=1 and `ram_addr`={addr[AW-1:2],2'b00}. In all other states `ram_ce`, `ram_we`, `ram_sel` and `ram_wdata` are 0.
- Byte select:
  - Byte: offset 0→1000, 1→0100, 2→0010, 3→0001.
  - Halfword: offset 0→1100, 2→0011.
  - Word: 1111.
- Write data: byte replicated ×4; halfword replicated ×2; word as-is.
- Loads use `ram_we`=0 and capture `ram_rdata` at the end of ACCESS. Stores use `ram_we`=1.
- Load extraction uses the same lane mapping as byte select. LB/LH sign-extend; LBU/LHU zero-extend.
- LL loads a word like LW and sets `llbit`=1 at the end of ACCESS.
- SC:
  - If `llbit`=1: write the word, `rsp_wdata`=1.
  - Else: `ram_ce`=1 with `ram_we`=0 and `ram_sel`=0 (no write), `rsp_wdata`=0.
  - SC always clears `llbit`. `rsp_wreg`=1 for SC and all loads; 0 for stores.
- `flush` clears `llbit` at the next edge and has priority over an LL completing in the same cycle. An access already in ACCESS still completes (committed); the FSM is not aborted.

## Timing
- Reset (`rst`=0 at an edge): state IDLE, `llbit`=0, every output 0 except `req_ready`=1.
- Accept at edge N → ACCESS during cycle N+1 (RAM write at edge N+2) → `rsp_valid` high in cycle N+2 only.
- Misaligned/no-op: `rsp_valid` in cycle N+1.
- Throughput: one op per 3 cycles, or per 2 cycles for faults/no-ops. `req_ready`=0 in ACCESS and RESP.
- Response outputs are registered and hold their value only while `rsp_valid`=1; otherwise they are 0.
- Reset mid-operation: the op is discarded and no response is issued. A store in ACCESS at the resetting edge is not guaranteed to be written.

## Structure
- Shared package: op encodings, FSM state encoding, exception bit positions, ChipEnable/WriteEnable constants.
- One sub-module, `lsu_lane_align`: combinational sel/write-data generation and load extraction/extension, reused on the request and response paths.

## Test plan
- Reset, SW 0x12345678 to 0x100 → ACCESS cycle shows `ram_sel`=1111, `ram_we`=1; `rsp_valid` 2 cycles after accept, `rsp_wreg`=0.
- SB 0xAB to 0x101 → `ram_sel`=0100, `ram_wdata`=0xABABABAB. Then LB 0x101 → `rsp_wdata`=0xFFFFFFAB; LBU → 0x000000AB.
- LH 0x102 with RAM word 0x1234_8001 → `ram_sel`=0011, `rsp_wdata`=0xFFFF8001. LW 0x102 → AdEL, `rsp_badaddr`=0x102, `ram_ce` never asserted.
- LL 0x200 then SC 0x200 (data 5) → word written, `rsp_wdata`=1, `llbit_o`=0. A second SC → no write, `rsp_wdata`=0.
- LL 0x200, `flush` pulse, then SC → SC fails with `rsp_wdata`=0. `flush` in the same cycle LL completes → `llbit_o` stays 0.
- `rst` low during ACCESS of a load → next cycle IDLE, `rsp_valid` never asserts, `req_ready`=1.
